// File: rtl/apb_ram_slave_pkg.sv
// Shared types and widths for the APB RAM completer.
//   APB_AW / APB_DW / APB_SW : address, data and strobe widths of the APB segment
//   apb_slv_state_e          : completer FSM states
//   apb_req_t                : request captured in the setup phase
//   strb_to_mask()           : expands byte strobes to a 32-bit bit mask
package apb_ram_slave_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;
    localparam int unsigned APB_SW = 4;

    typedef enum logic {APB_IDLE, APB_ACCESS} apb_slv_state_e;

    typedef struct packed {
        logic [APB_AW-1:0] addr;
        logic              write;
        logic [APB_DW-1:0] wdata;
        logic [APB_SW-1:0] strb;
    } apb_req_t;

    // Byte strobe k selects bits [8k+7:8k].
    function automatic logic [APB_DW-1:0] strb_to_mask(input logic [APB_SW-1:0] strb);
        logic [APB_DW-1:0] mask;
        mask = '0;
        for (int k = 0; k < int'(APB_SW); k++) begin
            mask[8*k +: 8] = {8{strb[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/apb_ram_bank.sv
// DEPTH x 32-bit flop array with asynchronous clear, per-byte write enables
// and a combinational read port.
//   clk, rst_n : clock, asynchronous active-low reset (clears every word)
//   waddr/wbe/wdata : write word index, byte enables, lane-positioned data
//   raddr/rdata     : combinational read port
module apb_ram_bank
    import apb_ram_slave_pkg::*;
#(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IW-1:0]     waddr,
    input  logic [APB_SW-1:0] wbe,
    input  logic [APB_DW-1:0] wdata,
    input  logic [IW-1:0]     raddr,
    output logic [APB_DW-1:0] rdata
);

    logic [APB_DW-1:0] mem [DEPTH];
    logic [APB_DW-1:0] wmask;

    assign wmask = strb_to_mask(wbe);

    // Byte-masked write; unselected lanes keep their old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (|wbe) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_ram_slave.sv
// APB4 completer exposing a word-organised, byte-writable scratch RAM.
// Programmable wait states, PSTRB lanes, PSLVERR on out-of-window accesses.
//   PCLK, PRESETn           : clock, asynchronous active-low reset
//   PSEL, PENABLE, PADDR,
//   PWRITE, PWDATA, PSTRB   : APB4 request signals
//   PRDATA, PREADY, PSLVERR : APB4 response; derived from state and counter
module apb_ram_slave
    import apb_ram_slave_pkg::*;
#(
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned       DEPTH       = 64,
    parameter int unsigned       WAIT_CYCLES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic              PWRITE,
    input  logic [APB_DW-1:0] PWDATA,
    input  logic [APB_SW-1:0] PSTRB,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned CW  = 4;
    localparam logic [APB_AW-1:0] WIN = APB_AW'(DEPTH * 4);

    apb_slv_state_e    state;
    logic [CW-1:0]     cnt;
    apb_req_t          req;

    logic [APB_AW-1:0] off;
    logic              hit;
    logic [IW-1:0]     idx;
    logic [APB_SW-1:0] wbe;
    logic [APB_DW-1:0] rdata;

    // Decode the latched address. A wrap below BASE_ADDR yields a huge
    // offset and therefore a miss; the low two address bits cannot move an
    // aligned window boundary, so comparing the full offset is exact.
    assign off = req.addr - BASE_ADDR;
    assign hit = off < WIN;
    assign idx = off[IW+1:2];

    assign PREADY  = (state == APB_ACCESS) && PSEL && PENABLE && (cnt == CW'(WAIT_CYCLES));
    assign PSLVERR = PREADY && !hit;
    assign PRDATA  = (PREADY && !req.write && hit) ? rdata : '0;

    // Writes commit only on the completing cycle of an in-window access.
    assign wbe = (PREADY && req.write && hit) ? req.strb : '0;

    // Request capture, wait counting and abort handling.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= APB_IDLE;
            cnt   <= '0;
            req   <= '0;
        end else begin
            case (state)
                APB_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        req   <= '{addr: PADDR, write: PWRITE, wdata: PWDATA, strb: PSTRB};
                        cnt   <= '0;
                        state <= APB_ACCESS;
                    end
                end
                APB_ACCESS: begin
                    if (!PSEL || PREADY) begin
                        cnt   <= '0;
                        state <= APB_IDLE;
                    end else if (PENABLE) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= APB_IDLE;
                end
            endcase
        end
    end

    apb_ram_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .waddr (idx),
        .wbe   (wbe),
        .wdata (req.wdata),
        .raddr (idx),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_apb_ram_slave.sv
// Directed bench for apb_ram_slave: one zero-wait and one 3-wait instance
// share the APB request bus and have private PSEL lines.
module tb_apb_ram_slave;

    logic        clk;
    logic        rst_n;
    logic        psel0, psel3;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;

    int checks = 0;
    int errors = 0;

    apb_ram_slave #(.BASE_ADDR(32'h1000_0000), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

    apb_ram_slave #(.BASE_ADDR(32'h1000_0000), .DEPTH(64), .WAIT_CYCLES(3)) dut3 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel3), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer. When idle_chk is set, every non-ready access cycle
    // must show PRDATA=0 and PSLVERR=0. scramble changes the bus after setup.
    task automatic xfer(input bit d3, input logic [31:0] a, input bit w,
                        input logic [31:0] wd, input logic [3:0] st,
                        input bit idle_chk, input bit scramble,
                        output logic [31:0] rd, output logic err, output int ncyc);
        bit done;
        @(posedge clk); #1;
        psel0 = !d3; psel3 = d3;
        paddr = a; pwrite = w; pwdata = wd; pstrb = st; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        if (scramble) begin
            paddr = a + 32'd4; pwdata = ~wd; pstrb = 4'hF; pwrite = !w;
        end
        done = 1'b0; ncyc = 0; rd = '0; err = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ncyc++;
            if (d3 ? pready3 : pready0) begin
                rd   = d3 ? prdata3 : prdata0;
                err  = d3 ? pslverr3 : pslverr0;
                done = 1'b1;
                break;
            end else if (idle_chk) begin
                chk("wait_prdata",  d3 ? prdata3 : prdata0, 32'h0);
                chk("wait_pslverr", {31'b0, d3 ? pslverr3 : pslverr0}, 32'h0);
            end
        end
        chk("xfer_done", {31'b0, done}, 32'h1);
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    // Word read with an expected value and response checks.
    task automatic rd_chk(input string tag, input bit d3, input logic [31:0] a,
                          input logic [31:0] exp, input logic exp_err);
        logic [31:0] rd; logic err; int n;
        xfer(d3, a, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, rd, err, n);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic wr_chk(input string tag, input bit d3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st, input logic exp_err);
        logic [31:0] rd; logic err; int n;
        xfer(d3, a, 1'b1, d, st, 1'b0, 1'b0, rd, err, n);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    // Load-store unit view: store places data on lanes, load extracts and extends.
    task automatic lsu_store(input logic [31:0] a, input int size, input logic [31:0] v);
        logic [31:0] d; logic [3:0] st; logic [3:0] one_b; logic [3:0] two_b;
        one_b = 4'b0001; two_b = 4'b0011;
        case (size)
            1:       begin d = {4{v[7:0]}};  st = one_b << a[1:0]; end
            2:       begin d = {2{v[15:0]}}; st = two_b << a[1:0]; end
            default: begin d = v;            st = 4'hF;            end
        endcase
        wr_chk("lsu_store", 1'b0, a, d, st, 1'b0);
    endtask

    task automatic lsu_load(input string tag, input logic [31:0] a, input int size,
                            input bit sgn, input logic [31:0] exp);
        logic [31:0] rd; logic err; int n; logic [31:0] v; logic [31:0] sh;
        xfer(1'b0, a, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, rd, err, n);
        sh = rd >> (8 * a[1:0]);
        case (size)
            1:       v = sgn ? {{24{sh[7]}},  sh[7:0]}  : {24'h0, sh[7:0]};
            2:       v = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            default: v = rd;
        endcase
        chk(tag, v, exp);
    endtask

    initial begin
        logic [31:0] rd; logic err; int n;

        rst_n = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_pready",  {31'b0, pready0},  32'h0);
        chk("rst_pslverr", {31'b0, pslverr0}, 32'h0);
        chk("rst_prdata",  prdata0, 32'h0);

        // Enable without setup is ignored
        @(posedge clk); #1; psel0 = 1'b1; penable = 1'b1;
        @(negedge clk); chk("nosetup_pready_a", {31'b0, pready0}, 32'h0);
        @(negedge clk); chk("nosetup_pready_b", {31'b0, pready0}, 32'h0);
        @(posedge clk); #1; psel0 = 1'b0; penable = 1'b0;

        // 1: read after reset, zero wait
        xfer(1'b0, 32'h1000_0000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, rd, err, n);
        chk("t1_latency", n, 32'd1);
        chk("t1_data", rd, 32'h0);
        chk("t1_err", {31'b0, err}, 32'h0);

        // 2: full write then single lane merge
        wr_chk("t2_w_full", 1'b0, 32'h1000_0008, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        rd_chk("t2_r_full", 1'b0, 32'h1000_0008, 32'hDEAD_BEEF, 1'b0);
        wr_chk("t2_w_lane", 1'b0, 32'h1000_0008, 32'h00AA_0000, 4'b0100, 1'b0);
        rd_chk("t2_r_lane", 1'b0, 32'h1000_0008, 32'hDEAA_BEEF, 1'b0);
        wr_chk("t2_w_none", 1'b0, 32'h1000_0008, 32'h1111_1111, 4'b0000, 1'b0);
        rd_chk("t2_r_none", 1'b0, 32'h1000_0008, 32'hDEAA_BEEF, 1'b0);
        rd_chk("t2_r_ofs",  1'b0, 32'h1000_000B, 32'hDEAA_BEEF, 1'b0);

        // 3: three wait states, outputs quiet until PREADY
        xfer(1'b1, 32'h1000_0004, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, rd, err, n);
        chk("t3_w_latency", n, 32'd4);
        chk("t3_w_err", {31'b0, err}, 32'h0);
        xfer(1'b1, 32'h1000_0004, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, rd, err, n);
        chk("t3_r_latency", n, 32'd4);
        chk("t3_r_data", rd, 32'hCAFE_F00D);
        // bus changes after setup must not matter
        xfer(1'b1, 32'h1000_000C, 1'b1, 32'h1234_5678, 4'b0011, 1'b1, 1'b1, rd, err, n);
        rd_chk("t3_latched", 1'b1, 32'h1000_000C, 32'h0000_5678, 1'b0);
        rd_chk("t3_latched_nb", 1'b1, 32'h1000_0010, 32'h0000_0000, 1'b0);

        // 4: window edges
        wr_chk("t4_w_last", 1'b0, 32'h1000_00FC, 32'h1234_5678, 4'hF, 1'b0);
        wr_chk("t4_w_past", 1'b0, 32'h1000_0100, 32'hAAAA_AAAA, 4'hF, 1'b1);
        wr_chk("t4_w_below", 1'b0, 32'h0FFF_FFFC, 32'hBBBB_BBBB, 4'hF, 1'b1);
        rd_chk("t4_r_past", 1'b0, 32'h1000_0100, 32'h0, 1'b1);
        rd_chk("t4_r_below", 1'b0, 32'h0FFF_FFFC, 32'h0, 1'b1);
        rd_chk("t4_r_last", 1'b0, 32'h1000_00FC, 32'h1234_5678, 1'b0);
        rd_chk("t4_r_word0", 1'b0, 32'h1000_0000, 32'h0, 1'b0);
        xfer(1'b1, 32'h1000_0100, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, rd, err, n);
        chk("t4_miss_latency", n, 32'd4);
        chk("t4_miss_err", {31'b0, err}, 32'h1);

        // 6: load/store unit traffic on every lane
        lsu_store(32'h1000_0010, 4, 32'h1122_3344);
        lsu_store(32'h1000_0014, 1, 32'h0000_0080);
        lsu_store(32'h1000_0015, 1, 32'h0000_007F);
        lsu_store(32'h1000_0016, 1, 32'h0000_0001);
        lsu_store(32'h1000_0017, 1, 32'h0000_00FE);
        lsu_store(32'h1000_0018, 2, 32'h0000_8001);
        lsu_store(32'h1000_001A, 2, 32'h0000_7FFE);
        lsu_load("t6_lw",   32'h1000_0010, 4, 1'b1, 32'h1122_3344);
        lsu_load("t6_lw_b", 32'h1000_0014, 4, 1'b1, 32'hFE01_7F80);
        lsu_load("t6_lb0",  32'h1000_0014, 1, 1'b1, 32'hFFFF_FF80);
        lsu_load("t6_lbu0", 32'h1000_0014, 1, 1'b0, 32'h0000_0080);
        lsu_load("t6_lb1",  32'h1000_0015, 1, 1'b1, 32'h0000_007F);
        lsu_load("t6_lb2",  32'h1000_0016, 1, 1'b1, 32'h0000_0001);
        lsu_load("t6_lb3",  32'h1000_0017, 1, 1'b1, 32'hFFFF_FFFE);
        lsu_load("t6_lbu3", 32'h1000_0017, 1, 1'b0, 32'h0000_00FE);
        lsu_load("t6_lh0",  32'h1000_0018, 2, 1'b1, 32'hFFFF_8001);
        lsu_load("t6_lh2",  32'h1000_001A, 2, 1'b1, 32'h0000_7FFE);
        lsu_load("t6_lb_h", 32'h1000_0013, 1, 1'b0, 32'h0000_0011);

        // 5a: PSEL dropped during wait states
        @(posedge clk); #1;
        psel3 = 1'b1; paddr = 32'h1000_0030; pwrite = 1'b1; pwdata = 32'h5555_5555; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk); chk("t5_abort_w0", {31'b0, pready3}, 32'h0);
        @(negedge clk); chk("t5_abort_w1", {31'b0, pready3}, 32'h0);
        @(posedge clk); #1; psel3 = 1'b0; penable = 1'b0;
        @(negedge clk); chk("t5_abort_idle", {31'b0, pready3}, 32'h0);
        rd_chk("t5_abort_r", 1'b1, 32'h1000_0030, 32'h0, 1'b0);

        // 5b: reset during a write
        @(posedge clk); #1;
        psel3 = 1'b1; paddr = 32'h1000_0034; pwrite = 1'b1; pwdata = 32'h6666_6666; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk); rst_n = 1'b0;
        #1 chk("t5_rst_pready", {31'b0, pready3}, 32'h0);
        psel3 = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_chk("t5_rst_r34", 1'b1, 32'h1000_0034, 32'h0, 1'b0);
        rd_chk("t5_rst_r04", 1'b1, 32'h1000_0004, 32'h0, 1'b0);
        xfer(1'b1, 32'h1000_0034, 1'b1, 32'h7777_0001, 4'hF, 1'b1, 1'b0, rd, err, n);
        chk("t5_post_latency", n, 32'd4);
        rd_chk("t5_post_r", 1'b1, 32'h1000_0034, 32'h7777_0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
